// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: byte-lane data memory plus the MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [2:0]  mem_modeM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        MisalignW,
  output logic        misalign_sticky
);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] r;
    r = b;
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    logic signed [31:0] r;
    r = h;
    return r;
  endfunction

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off_raw;
  logic [1:0]        off_a;
  logic              is_byte, is_half, is_word;
  logic              mis_st, mis_ld;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic              we;

  logic              RegWriteW_q;
  logic [1:0]        ResultSrcW_q;
  logic [31:0]       ALUResultW_q;
  logic [31:0]       PCPlus4W_q;
  logic [4:0]        RdW_q;
  logic [31:0]       raw_q;
  logic [1:0]        offW_q;
  logic [2:0]        modeW_q;
  logic              kill_q;

  assign idx     = ALUResultM[ADDR_W+1:2];
  assign off_raw = ALUResultM[1:0];
  assign is_byte = (mem_modeM == MODE_B) || (mem_modeM == MODE_BU);
  assign is_half = (mem_modeM == MODE_H) || (mem_modeM == MODE_HU);
  assign is_word = (mem_modeM == MODE_W);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic is_load;
  logic mis_w_q;
  logic sticky_q;

  // A load is recognised by the writeback mux selecting memory data.
  assign is_load    = !MemWriteM && (ResultSrcM == 2'b01);
  assign misaligned = (is_half && off_raw[0]) || (is_word && (off_raw != 2'b00));
  assign mis_st     = MemWriteM && misaligned;
  assign mis_ld     = is_load && misaligned;
  assign off_a      = off_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_w_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      mis_w_q  <= mis_st || mis_ld;
      sticky_q <= sticky_q || mis_st || mis_ld;
    end
  end

  assign MisalignW       = mis_w_q;
  assign misalign_sticky = sticky_q;
`else
  assign mis_st = 1'b0;
  assign mis_ld = 1'b0;
  // Without trapping, sub-word low address bits are dropped to force alignment.
  assign off_a  = is_word ? 2'b00 : (is_half ? {off_raw[1], 1'b0} : off_raw);

  assign MisalignW       = 1'b0;
  assign misalign_sticky = 1'b0;
`endif

  always_comb begin
    be    = 4'b0000;
    wlane = WriteDataM;
    if (is_byte) begin
      be    = 4'b0001 << off_a;
      wlane = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      be    = off_a[1] ? 4'b1100 : 4'b0011;
      wlane = {2{WriteDataM[15:0]}};
    end else if (is_word) begin
      be    = 4'b1111;
    end
  end

  assign we = MemWriteM && !rst && !mis_st;

  // Memory array: byte-lane writes, no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // MEM/WB boundary: raw read data captured pre-write alongside the pass-through fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW_q  <= 1'b0;
      ResultSrcW_q <= 2'b00;
      ALUResultW_q <= 32'd0;
      PCPlus4W_q   <= 32'd0;
      RdW_q        <= 5'd0;
      raw_q        <= 32'd0;
      offW_q       <= 2'b00;
      modeW_q      <= 3'b000;
      kill_q       <= 1'b0;
    end else begin
      RegWriteW_q  <= RegWriteM && !mis_ld;
      ResultSrcW_q <= ResultSrcM;
      ALUResultW_q <= ALUResultM;
      PCPlus4W_q   <= PCPlus4M;
      RdW_q        <= RdM;
      raw_q        <= mem[idx];
      offW_q       <= off_a;
      modeW_q      <= mem_modeM;
      kill_q       <= mis_ld;
    end
  end

  always_comb begin
    logic [7:0]  bsel;
    logic [15:0] hsel;
    bsel      = raw_q[8*offW_q +: 8];
    hsel      = offW_q[1] ? raw_q[31:16] : raw_q[15:0];
    ReadDataW = 32'd0;
    if (!kill_q) begin
      case (modeW_q)
        MODE_B:  ReadDataW = sext8(bsel);
        MODE_H:  ReadDataW = sext16(hsel);
        MODE_W:  ReadDataW = raw_q;
        MODE_BU: ReadDataW = {24'd0, bsel};
        MODE_HU: ReadDataW = {16'd0, hsel};
        default: ReadDataW = 32'd0;
      endcase
    end
  end

  assign RegWriteW  = RegWriteW_q;
  assign ResultSrcW = ResultSrcW_q;
  assign ALUResultW = ALUResultW_q;
  assign PCPlus4W   = PCPlus4W_q;
  assign RdW        = RdW_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage: store/load sizing, wrap, illegal modes, reset, misalign.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [2:0]  mem_modeM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        MisalignW, misalign_sticky;

  int ncmp = 0;
  int nmis = 0;
  logic [31:0] pc = 32'h100;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M), .mem_modeM(mem_modeM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .MisalignW(MisalignW), .misalign_sticky(misalign_sticky)
  );

  typedef struct {
    logic        st;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction at the falling edge, then sample 1ns after the capturing edge.
  task automatic step(input logic r, input logic st, input logic [2:0] mode,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    rst        = r;
    MemWriteM  = st;
    RegWriteM  = !st;
    ResultSrcM = st ? 2'b00 : 2'b01;
    mem_modeM  = mode;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rd;
    pc         = pc + 32'd4;
    PCPlus4M   = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic [2:0] mode, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] rd, input logic chk,
                     input logic [31:0] exp);
    vec_t v;
    v.st = st; v.mode = mode; v.addr = addr; v.wd = wd; v.rd = rd; v.chk = chk; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic idle_all_zero(input string tag);
    check({tag, "_RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
    check({tag, "_ResultSrcW"}, {30'd0, ResultSrcW}, 32'd0);
    check({tag, "_ALUResultW"}, ALUResultW, 32'd0);
    check({tag, "_ReadDataW"}, ReadDataW, 32'd0);
    check({tag, "_PCPlus4W"}, PCPlus4W, 32'd0);
    check({tag, "_RdW"}, {27'd0, RdW}, 32'd0);
    check({tag, "_MisalignW"}, {31'd0, MisalignW}, 32'd0);
    check({tag, "_sticky"}, {31'd0, misalign_sticky}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    ALUResultM = 32'd0; WriteDataM = 32'd0; RdM = 5'd0; PCPlus4M = 32'd0; mem_modeM = 3'b000;

    add(1, 3'b010, 32'h40, 32'hDEADBEEF, 5'd1, 0, 32'h0);
    add(0, 3'b010, 32'h40, 32'h0,        5'd5, 1, 32'hDEADBEEF);
    add(1, 3'b010, 32'h40, 32'h0,        5'd0, 0, 32'h0);
    add(1, 3'b000, 32'h43, 32'h00000080, 5'd0, 0, 32'h0);
    add(0, 3'b000, 32'h43, 32'h0,        5'd6, 1, 32'hFFFFFF80);
    add(0, 3'b100, 32'h43, 32'h0,        5'd7, 1, 32'h00000080);
    add(0, 3'b010, 32'h40, 32'h0,        5'd8, 1, 32'h80000000);
    add(1, 3'b001, 32'h42, 32'h00008001, 5'd0, 0, 32'h0);
    add(0, 3'b001, 32'h42, 32'h0,        5'd9, 1, 32'hFFFF8001);
    add(0, 3'b101, 32'h42, 32'h0,        5'd10, 1, 32'h00008001);
    add(1, 3'b000, 32'h41, 32'h0000007F, 5'd0, 0, 32'h0);
    add(0, 3'b000, 32'h41, 32'h0,        5'd11, 1, 32'h0000007F);
    add(0, 3'b010, 32'h40, 32'h0,        5'd12, 1, 32'h80017F00);
    add(0, 3'b001, 32'h40, 32'h0,        5'd13, 1, 32'h00007F00);
    add(1, 3'b010, 32'h1000, 32'h11223344, 5'd0, 0, 32'h0);
    add(0, 3'b010, 32'h0,  32'h0,        5'd14, 1, 32'h11223344);
    add(1, 3'b011, 32'h0,  32'hFFFFFFFF, 5'd0, 0, 32'h0);
    add(0, 3'b010, 32'h0,  32'h0,        5'd15, 1, 32'h11223344);
    add(1, 3'b110, 32'h0,  32'hFFFFFFFF, 5'd0, 0, 32'h0);
    add(0, 3'b100, 32'h0,  32'h0,        5'd16, 1, 32'h00000044);
    add(0, 3'b011, 32'h0,  32'h0,        5'd17, 1, 32'h0);
    add(0, 3'b111, 32'h0,  32'h0,        5'd18, 1, 32'h0);

    // Reset state
    @(posedge clk); #1;
    idle_all_zero("reset");
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].st, tbl[i].mode, tbl[i].addr, tbl[i].wd, tbl[i].rd);
      check($sformatf("v%0d_RegWriteW", i), {31'd0, RegWriteW}, {31'd0, !tbl[i].st});
      check($sformatf("v%0d_RdW", i), {27'd0, RdW}, {27'd0, tbl[i].rd});
      check($sformatf("v%0d_ALUResultW", i), ALUResultW, tbl[i].addr);
      check($sformatf("v%0d_PCPlus4W", i), PCPlus4W, pc);
      check($sformatf("v%0d_ResultSrcW", i), {30'd0, ResultSrcW}, tbl[i].st ? 32'd0 : 32'd1);
      check($sformatf("v%0d_MisalignW", i), {31'd0, MisalignW}, 32'd0);
      if (tbl[i].chk) check($sformatf("v%0d_ReadDataW", i), ReadDataW, tbl[i].exp);
    end

`ifdef MISALIGN_TRAP_EN
    step(1'b0, 1'b0, 3'b010, 32'h41, 32'h0, 5'd20);
    check("mis_ld_MisalignW", {31'd0, MisalignW}, 32'd1);
    check("mis_ld_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("mis_ld_ReadDataW", ReadDataW, 32'd0);
    check("mis_ld_sticky", {31'd0, misalign_sticky}, 32'd1);
    step(1'b0, 1'b1, 3'b010, 32'h41, 32'hCAFEBABE, 5'd0);
    check("mis_st_MisalignW", {31'd0, MisalignW}, 32'd1);
    step(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 5'd21);
    check("after_mis_MisalignW", {31'd0, MisalignW}, 32'd0);
    check("after_mis_sticky", {31'd0, misalign_sticky}, 32'd1);
    check("after_mis_RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("mis_st_nowrite", ReadDataW, 32'h80017F00);
    step(1'b0, 1'b0, 3'b001, 32'h43, 32'h0, 5'd22);
    check("mis_lh_MisalignW", {31'd0, MisalignW}, 32'd1);
    check("mis_lh_ReadDataW", ReadDataW, 32'd0);
`else
    step(1'b0, 1'b1, 3'b010, 32'h43, 32'h12345678, 5'd0);
    check("align_sw_MisalignW", {31'd0, MisalignW}, 32'd0);
    step(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 5'd20);
    check("align_lw_ReadDataW", ReadDataW, 32'h12345678);
    check("align_lw_MisalignW", {31'd0, MisalignW}, 32'd0);
    check("align_lw_sticky", {31'd0, misalign_sticky}, 32'd0);
    step(1'b0, 1'b0, 3'b001, 32'h43, 32'h0, 5'd21);
    check("align_lh_ReadDataW", ReadDataW, 32'h00001234);
`endif

    // Reset mid-stream suppresses the store presented in the same cycle
    step(1'b0, 1'b1, 3'b010, 32'h80, 32'h55555555, 5'd0);
    step(1'b0, 1'b0, 3'b010, 32'h80, 32'h0, 5'd3);
    check("pre_rst_ReadDataW", ReadDataW, 32'h55555555);
    step(1'b1, 1'b1, 3'b010, 32'h80, 32'hAAAAAAAA, 5'd4);
    idle_all_zero("midrst");
    step(1'b0, 1'b0, 3'b010, 32'h80, 32'h0, 5'd23);
    check("post_rst_ReadDataW", ReadDataW, 32'h55555555);
    check("post_rst_RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("post_rst_RdW", {27'd0, RdW}, 32'd23);
    check("post_rst_sticky", {31'd0, misalign_sticky}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
